// File: rtl/wl_seq_decoder.sv
// wl_seq_decoder: sequenced, registered SRAM wordline decoder.
// Each access runs PRE (bitline precharge), WL (one active-low wordline),
// then REC (all lines high, done pulse). Requests use a valid/ready handshake.
// Optional feature macro: WL_BURST_EN enables multi-beat bursts via req_len.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. While the block
// is busy, req_valid is ignored and the requester must keep it asserted,
// with address/we/len held stable, until it is accepted.
module wl_seq_decoder #(
    parameter int ADDR_W     = 6,
    parameter int MSB_W      = 3,
    parameter int PRE_CYCLES = 1,
    parameter int WL_CYCLES  = 2,
    localparam int NUM_WL    = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [2:0]        req_len,
    output logic [NUM_WL-1:0] wordline,
    output logic              precharge_n,
    output logic              sense_en,
    output logic              wr_en,
    output logic              done,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int LSB_W   = ADDR_W - MSB_W;
    localparam int NUM_GRP = 2 ** MSB_W;
    localparam int NUM_LSB = 2 ** LSB_W;
    localparam int CNT_MAX = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_WL   = 2'd2,
        S_REC  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               r_we;
    logic               w_we_nxt;
    logic               w_last_beat;

`ifdef WL_BURST_EN
    logic [2:0]         r_len;
    logic [2:0]         w_len_nxt;
    assign w_last_beat = (r_len == 3'd0);
`else
    // Single-beat build: req_len carries no meaning and no counter exists.
    logic               w_unused_len;
    assign w_unused_len = ^req_len;
    assign w_last_beat  = 1'b1;
`endif

    logic [NUM_GRP-1:0] w_grp;
    logic [NUM_LSB-1:0] w_lsb;
    logic [NUM_WL-1:0]  w_line;
    logic [NUM_WL-1:0]  w_wl_nxt;
    logic               w_pre_n_nxt;
    logic               w_sense_nxt;
    logic               w_wr_nxt;
    logic               w_done_nxt;

    logic [NUM_WL-1:0]  r_wordline;
    logic               r_precharge_n;
    logic               r_sense_en;
    logic               r_wr_en;
    logic               r_done;

    // Next-state logic: sequence PRE -> WL -> REC, with per-phase cycle counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_we_nxt    = r_we;
`ifdef WL_BURST_EN
        w_len_nxt   = r_len;
`endif
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = CNT_W'(PRE_CYCLES - 1);
                    w_addr_nxt  = req_addr;
                    w_we_nxt    = req_we;
`ifdef WL_BURST_EN
                    w_len_nxt   = req_len;
`endif
                end
            end
            S_PRE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WL;
                    w_cnt_nxt   = CNT_W'(WL_CYCLES - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_WL: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_REC;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_REC: begin
                if (!w_last_beat) begin
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = CNT_W'(PRE_CYCLES - 1);
                    w_addr_nxt  = r_addr + ADDR_W'(1);
`ifdef WL_BURST_EN
                    w_len_nxt   = r_len - 3'd1;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Two-level predecode of the next address: group one-hot AND line one-hot.
    always_comb begin
        w_grp = '0;
        w_lsb = '0;
        w_grp[w_addr_nxt[ADDR_W-1 -: MSB_W]] = 1'b1;
        w_lsb[w_addr_nxt[LSB_W-1:0]]         = 1'b1;
        w_line = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            for (int l = 0; l < NUM_LSB; l++) begin
                w_line[g * NUM_LSB + l] = w_grp[g] & w_lsb[l];
            end
        end
    end

    // Output decode from next state so registered outputs line up with the state.
    always_comb begin
        w_wl_nxt    = (w_state_nxt == S_WL) ? ~w_line : '1;
        w_pre_n_nxt = (w_state_nxt != S_PRE);
        w_wr_nxt    = (w_state_nxt == S_WL) && w_we_nxt;
        w_sense_nxt = (w_state_nxt == S_WL) && !w_we_nxt && (w_cnt_nxt == '0);
        w_done_nxt  = (w_state_nxt == S_REC);
    end

    // State, counter and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
`ifdef WL_BURST_EN
            r_len   <= 3'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_we    <= w_we_nxt;
`ifdef WL_BURST_EN
            r_len   <= w_len_nxt;
`endif
        end
    end

    // Registered array controls: glitch-free, no input-to-output paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wordline    <= '1;
            r_precharge_n <= 1'b1;
            r_sense_en    <= 1'b0;
            r_wr_en       <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_wordline    <= w_wl_nxt;
            r_precharge_n <= w_pre_n_nxt;
            r_sense_en    <= w_sense_nxt;
            r_wr_en       <= w_wr_nxt;
            r_done        <= w_done_nxt;
        end
    end

    assign wordline    = r_wordline;
    assign precharge_n = r_precharge_n;
    assign sense_en    = r_sense_en;
    assign wr_en       = r_wr_en;
    assign done        = r_done;
    assign req_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;

endmodule

// File: doc/wl_seq_decoder.md
Name: wl_seq_decoder

Overview:
- Parametrised, sequenced wordline decoder and access controller for the SRAM macro.
- Replaces purely combinational address-to-wordline decoding with a registered, glitch-free wordline driver.
- Adds precharge / wordline / recovery timing, a valid-ready request handshake, and read/write strobes.
- Sits between the memory controller and the bitcell array.

Parameters:
- ADDR_W, 6: address width; number of wordlines NUM_WL = 2**ADDR_W.
- MSB_W, 3: predecode split; upper MSB_W bits select the group, lower ADDR_W-MSB_W bits select the line within the group. Legal range 1 <= MSB_W < ADDR_W.
- PRE_CYCLES, 1: precharge duration in cycles, >= 1.
- WL_CYCLES, 2: wordline pulse width in cycles, >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  access request.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  wordline address.
- req_we  in  1  1 = write, 0 = read.
- req_len  in  3  extra burst beats; used only with WL_BURST_EN.
- wordline  out  NUM_WL  active-low wordlines; at most one bit low.
- precharge_n  out  1  active-low bitline precharge.
- sense_en  out  1  sense-amp enable, reads only.
- wr_en  out  1  write-driver enable, writes only.
- done  out  1  one-cycle pulse per completed beat.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, active-high): on a clock edge with rst=1, the block enters IDLE and sets:
  - wordline = all ones
  - precharge_n = 1, sense_en = 0, wr_en = 0, done = 0, busy = 0
  - req_ready = 1 once rst deasserts
- Reset mid-operation: the next edge aborts the access. All wordlines go high, no done pulse is issued, and any remaining burst count is discarded.
- Outputs:
  - wordline, precharge_n, sense_en, wr_en and done are registered, so there are no combinational paths from inputs.
  - req_ready and busy are decoded from registered state.
- Decode:
  - Two-level predecode on the latched address: an MSB group enable is ANDed with the LSB one-hot.
  - Target line is driven low; all others stay high.
  - Address is latched only at handshake, so req_addr may change afterwards.
- FSM states:
  - IDLE
    - req_ready = 1.
    - On req_valid & req_ready: latch addr/we/len, go to PRE.
    - req_valid while not IDLE is ignored; the requester must hold it.
  - PRE
    - precharge_n = 0 for PRE_CYCLES cycles; all wordlines high.
    - Then go to WL.
  - WL
    - wordline[addr] = 0 for WL_CYCLES cycles; precharge_n = 1.
    - Write: wr_en = 1 in every WL cycle.
    - Read: sense_en = 1 in the last WL cycle only.
    - Then go to REC.
  - REC
    - One cycle with all wordlines high (break-before-make); done = 1.
    - If burst beats remain: addr <= addr+1 modulo NUM_WL (63 wraps to 0), decrement the count, go to PRE.
    - Otherwise go to IDLE.
- Latency, taking the handshake edge as cycle 0:
  - PRE occupies cycles 1..P; WL occupies P+1..P+W; done is high in cycle P+W+1.
  - Defaults (P=1, W=2): wordline low in cycles 2-3, done in cycle 4, next accept at cycle 5.
- No two wordlines are ever low in the same cycle, and a wordline is never low while precharge_n = 0.

Optional Feature:
- WL_BURST_EN defined:
  - req_len = N performs N+1 consecutive beats with auto-incrementing, wrapping address.
  - Each beat runs PRE/WL/REC and pulses done.
  - busy stays high and req_ready low across the whole burst.
- WL_BURST_EN undefined:
  - req_len is ignored and treated as 0; every request is a single beat.
  - No burst counter is synthesised.

Test Plan:
- Reset: rst=1 for 2 cycles -> wordline = 64'hFFFF_FFFF_FFFF_FFFF, precharge_n=1, sense_en=wr_en=done=busy=0; req_ready=1 after release.
- Read addr 0, defaults: handshake at cycle 0 -> precharge_n=0 in cycle 1; wordline[0]=0 in cycles 2-3; sense_en=1 in cycle 3 only; done in cycle 4; req_ready back at 1 in cycle 5.
- Write addr 63, we=1 -> wordline[63]=0 and wr_en=1 in cycles 2-3; sense_en stays 0; all other 63 lines stay high throughout.
- Request while busy: hold req_valid with addr 5 from cycle 1 -> not accepted until cycle 5; wordline[5] low in cycles 7-8.
- Reset mid-WL: rst asserted in cycle 2 of a read -> by cycle 3 all wordlines are high, no done pulse, IDLE with req_ready=1 after release.
- Burst (WL_BURST_EN): addr 62, len 3 -> wordlines 62, 63, 0, 1 each low for 2 cycles, 4 done pulses, one cycle all-high between beats.
  - Same stimulus without the macro -> only line 62 is driven and 1 done pulse is issued.
